// File: rtl/mma_fifo_pkg.sv
// ---------------------------------------------------------------------------
// mma_fifo_pkg
// Shared definitions for the s8-vector packer / unpacker pair feeding the
// MMA array: default vector length, word geometry, pointer widths and the
// per-bank ping-pong state encoding.
// ---------------------------------------------------------------------------
package mma_fifo_pkg;

    localparam int VLEN_DEFAULT  = 16;
    localparam int WORD_BYTES    = 4;
    localparam int WORDS_PER_ROW = VLEN_DEFAULT / WORD_BYTES;

    // Row pointer addresses VLEN rows; row count needs one extra bit to hold VLEN.
    localparam int ROW_PTR_W  = $clog2(VLEN_DEFAULT);
    localparam int ROW_CNT_W  = $clog2(VLEN_DEFAULT) + 1;
    localparam int WORD_IDX_W = $clog2(WORDS_PER_ROW);

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

endpackage

// File: rtl/fifo_to_vec_s8_if.sv
// ---------------------------------------------------------------------------
// fifo_to_vec_s8_if
// Bundles the word input stream, the vector output stream and the sticky
// overflow flag of fifo_to_vec_s8.
//   slave  : view used by fifo_to_vec_s8 (consumes words, produces vectors)
//   master : view used by the producer/consumer environment
//
// Handshake semantics (both streams): a transfer happens on a rising clk edge
// where valid && ready. A source holds valid and its payload stable until the
// transfer; ready may rise or fall at any time and carries no commitment
// before valid is seen.
// ---------------------------------------------------------------------------
interface fifo_to_vec_s8_if import mma_fifo_pkg::*; #(
    parameter int VLEN = VLEN_DEFAULT
) ();

    localparam int CNT_W = $clog2(VLEN) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [3:0]        in_mask;
    logic              in_row_switch;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [VLEN*8-1:0] out_vec_s8;
    logic              out_last;
    logic [CNT_W-1:0]  out_rows;

    logic              err_ovf;

    modport slave (
        input  in_valid, in_data, in_mask, in_row_switch, in_last,
        output in_ready,
        output out_valid, out_vec_s8, out_last, out_rows,
        input  out_ready,
        output err_ovf
    );

    modport master (
        output in_valid, in_data, in_mask, in_row_switch, in_last,
        input  in_ready,
        input  out_valid, out_vec_s8, out_last, out_rows,
        output out_ready,
        input  err_ovf
    );

endinterface

// File: rtl/vec_s8_row_asm.sv
// ---------------------------------------------------------------------------
// vec_s8_row_asm
// Assembles one VLEN-byte row from 32-bit byte-masked words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   word_en     : a word is accepted this cycle
//   word_data   : byte k at [8k+7:8k]
//   word_mask   : byte k valid; masked-off bytes are written as zero
//   row_switch  : accepted word ends the row
//   tile_last   : accepted word ends the tile (also ends the row)
//   row_data    : current row with the presented word merged in
//   commit      : row_data is complete and must be stored this cycle
// Word w lands in row bytes 4w..4w+3. The last word slot forces a commit.
// After a commit the row register is cleared, so bytes not written in the
// next row read as zero.
// ---------------------------------------------------------------------------
module vec_s8_row_asm import mma_fifo_pkg::*; #(
    parameter int VLEN = VLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              word_en,
    input  logic [31:0]       word_data,
    input  logic [3:0]        word_mask,
    input  logic              row_switch,
    input  logic              tile_last,
    output logic [VLEN*8-1:0] row_data,
    output logic              commit
);

    localparam int WPR    = VLEN / WORD_BYTES;
    localparam int WIDX_W = $clog2(WPR);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WPR - 1);

    logic [VLEN*8-1:0] row_q;
    logic [WIDX_W-1:0] widx;

    always_comb begin
        row_data = row_q;
        for (int k = 0; k < WORD_BYTES; k++) begin
            row_data[(int'(widx) * WORD_BYTES + k) * 8 +: 8] =
                word_mask[k] ? word_data[k*8 +: 8] : 8'h00;
        end
    end

    assign commit = word_en && (tile_last || row_switch || (widx == LAST_WORD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            widx  <= '0;
        end else if (word_en) begin
            if (commit) begin
                row_q <= '0;
                widx  <= '0;
            end else begin
                row_q <= row_data;
                widx  <= widx + WIDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_to_vec_s8.sv
// ---------------------------------------------------------------------------
// fifo_to_vec_s8
// Unpacks byte-masked 32-bit words into VLEN-byte s8 vectors. Rows are
// collected into a two-bank ping-pong buffer; each closed tile is replayed
// as a contiguous vector burst.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : in_* word stream, out_* vector stream, err_ovf
//   dbg_bank_state : {bank1, bank0} bank_state_e, for observation only
// A tile closes on in_last, or when a row commits into the last row slot
// without in_last (overflow, sticky err_ovf). Banks are written and drained
// in strict alternation, so tiles leave in write order.
// ---------------------------------------------------------------------------
module fifo_to_vec_s8 import mma_fifo_pkg::*; #(
    parameter int VLEN = VLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_to_vec_s8_if.slave bus,
    output logic [3:0]      dbg_bank_state
);

    localparam int PTR_W = $clog2(VLEN);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(VLEN - 1);

    // Bank storage: not reset, reads are masked by the full flags.
    logic [VLEN*8-1:0] bank_mem [2][VLEN];

    bank_state_e      bank_state [2];
    logic [1:0]       full;
    logic [CNT_W-1:0] rows [2];
    logic             wsel, rsel;
    logic [PTR_W-1:0] wrow, rptr;
    logic             err_ovf_q;

    logic              accept, commit, tile_close, ovf_close;
    logic              out_valid_i, out_last_i, out_hs;
    logic [VLEN*8-1:0] row_data;

    // A bank holds a closed tile from close until its last row is handed out.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            full[b] = (bank_state[b] == FULL) || (bank_state[b] == DRAINING);
        end
    end

    // in_ready depends only on registered state: no path from out_ready.
    assign bus.in_ready = !full[wsel];
    assign accept       = bus.in_valid && bus.in_ready;

    vec_s8_row_asm #(.VLEN(VLEN)) u_row_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_en    (accept),
        .word_data  (bus.in_data),
        .word_mask  (bus.in_mask),
        .row_switch (bus.in_row_switch),
        .tile_last  (bus.in_last),
        .row_data   (row_data),
        .commit     (commit)
    );

    assign tile_close = commit && (bus.in_last || (wrow == LAST_ROW));
    assign ovf_close  = commit && !bus.in_last && (wrow == LAST_ROW);

    // Read side
    assign out_valid_i    = full[rsel];
    assign out_last_i     = out_valid_i && ({1'b0, rptr} == (rows[rsel] - CNT_W'(1)));
    assign out_hs         = out_valid_i && bus.out_ready;
    assign bus.out_valid  = out_valid_i;
    assign bus.out_vec_s8 = out_valid_i ? bank_mem[rsel][rptr] : '0;
    assign bus.out_last   = out_last_i;
    assign bus.out_rows   = out_valid_i ? rows[rsel] : '0;
    assign bus.err_ovf    = err_ovf_q;

    assign dbg_bank_state = {bank_state[1], bank_state[0]};

    always_ff @(posedge clk) begin
        if (commit) begin
            bank_mem[wsel][wrow] <= row_data;
        end
    end

    // Write/read pointers. Close and drain-complete touch different banks,
    // so both updates apply in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            wrow      <= '0;
            rptr      <= '0;
            rows[0]   <= '0;
            rows[1]   <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            if (commit) begin
                if (tile_close) begin
                    rows[wsel] <= {1'b0, wrow} + CNT_W'(1);
                    wsel       <= !wsel;
                    wrow       <= '0;
                end else begin
                    wrow <= wrow + PTR_W'(1);
                end
            end
            if (ovf_close) begin
                err_ovf_q <= 1'b1;
            end
            if (out_hs) begin
                if (out_last_i) begin
                    rptr <= '0;
                    rsel <= !rsel;
                end else begin
                    rptr <= rptr + PTR_W'(1);
                end
            end
        end
    end

    // Per-bank lifecycle. A one-word tile goes FREE -> FULL, a one-row tile
    // goes FULL -> FREE, skipping the intermediate states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= FREE;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                case (bank_state[b])
                    FREE: begin
                        if (accept && (wsel == 1'(b))) begin
                            bank_state[b] <= tile_close ? FULL : FILLING;
                        end
                    end
                    FILLING: begin
                        if (tile_close && (wsel == 1'(b))) begin
                            bank_state[b] <= FULL;
                        end
                    end
                    FULL: begin
                        if (out_hs && (rsel == 1'(b))) begin
                            bank_state[b] <= out_last_i ? FREE : DRAINING;
                        end
                    end
                    DRAINING: begin
                        if (out_hs && out_last_i && (rsel == 1'(b))) begin
                            bank_state[b] <= FREE;
                        end
                    end
                    default: bank_state[b] <= FREE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_to_vec_s8.sv
// ---------------------------------------------------------------------------
// tb_fifo_to_vec_s8
// Self-checking bench for fifo_to_vec_s8 (VLEN=16). A reference row/tile
// model pushes expected vectors when words are accepted; a negedge monitor
// pops and compares on every output handshake and checks output stability
// during stalls. Scenario tasks add their own direct checks.
// ---------------------------------------------------------------------------
module tb_fifo_to_vec_s8;
    import mma_fifo_pkg::*;

    localparam int VLEN  = 16;
    localparam int WPR   = VLEN / 4;
    localparam int CNT_W = $clog2(VLEN) + 1;
    localparam int VW    = VLEN * 8;
    localparam int EW    = VW + 1 + CNT_W;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dbg_bank_state;

    always #5 clk = ~clk;

    fifo_to_vec_s8_if #(.VLEN(VLEN)) bus ();

    fifo_to_vec_s8 #(.VLEN(VLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .dbg_bank_state (dbg_bank_state)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- scoreboard / model ----------------
    logic [EW-1:0] exp_q[$];
    logic [VW-1:0] m_tile[$];
    logic [VW-1:0] m_row = '0;
    int            m_w = 0;

    logic [EW-1:0] mon_e;
    logic          stall_prev = 1'b0;
    logic [VW-1:0] prev_vec;
    logic          prev_last;
    logic          sent_done;

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic [31:0] d, input logic [3:0] m,
                                input logic rs, input logic last);
        int n;
        for (int k = 0; k < 4; k++) begin
            m_row[(m_w*4 + k)*8 +: 8] = m[k] ? d[k*8 +: 8] : 8'h00;
        end
        if (last || rs || (m_w == WPR - 1)) begin
            m_tile.push_back(m_row);
            m_row = '0;
            m_w   = 0;
            if (last || (m_tile.size() == VLEN)) begin
                n = m_tile.size();
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back({m_tile[i], (i == n - 1), CNT_W'(n)});
                end
                m_tile.delete();
            end
        end else begin
            m_w++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_tile.delete();
        m_row = '0;
        m_w   = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [31:0] d, input logic [3:0] m,
                             input logic rs, input logic last);
        int n = 0;
        bus.in_valid      = 1'b1;
        bus.in_data       = d;
        bus.in_mask       = m;
        bus.in_row_switch = rs;
        bus.in_last       = last;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 1000 cycles", bus.in_ready);
        end
        sync();
        if (n < 1000) model_accept(d, m, rs, last);
        bus.in_valid      = 1'b0;
        bus.in_data       = $urandom;
        bus.in_mask       = 4'($urandom_range(0, 15));
        bus.in_row_switch = 1'($urandom_range(0, 1));
        bus.in_last       = 1'($urandom_range(0, 1));
    endtask

    task automatic send_tile(input int n_rows);
        int nw;
        logic rs;
        for (int r = 0; r < n_rows; r++) begin
            nw = $urandom_range(1, WPR);
            for (int w = 0; w < nw; w++) begin
                rs = (w == nw - 1) && ((nw < WPR) || ($urandom_range(0, 1) == 1));
                send_word($urandom, 4'($urandom_range(0, 15)), rs,
                          (r == n_rows - 1) && (w == nw - 1));
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && n < budget) begin
            sync();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL drain_timeout: %0d vectors outstanding, out_valid=%b, required 0 and 0",
                     exp_q.size(), bus.out_valid);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                tests++;
                if (bus.out_valid !== 1'b1 || bus.out_vec_s8 !== prev_vec || bus.out_last !== prev_last) begin
                    fails++;
                    $display("FAIL stall_hold: valid=%b last=%b vec=%h, required 1 %b %h",
                             bus.out_valid, bus.out_last, bus.out_vec_s8, prev_last, prev_vec);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL out_unexpected: vec=%h last=%b rows=%0d, required no output",
                             bus.out_vec_s8, bus.out_last, bus.out_rows);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({bus.out_vec_s8, bus.out_last, bus.out_rows} !== mon_e) begin
                        fails++;
                        $display("FAIL out_vector: vec=%h last=%b rows=%0d, required vec=%h last=%b rows=%0d",
                                 bus.out_vec_s8, bus.out_last, bus.out_rows,
                                 mon_e[EW-1 -: VW], mon_e[CNT_W], mon_e[CNT_W-1:0]);
                    end
                end
            end
            stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            prev_vec   = bus.out_vec_s8;
            prev_last  = bus.out_last;
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic check_reset_outputs(input string tag);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_vec_s8 !== '0 ||
            bus.out_last !== 1'b0 || bus.out_rows !== '0 || bus.err_ovf !== 1'b0 ||
            dbg_bank_state !== 4'd0) begin
            fails++;
            $display("FAIL %s: in_ready=%b out_valid=%b vec=%h last=%b rows=%0d ovf=%b st=%h, required 1 0 0 0 0 0 0",
                     tag, bus.in_ready, bus.out_valid, bus.out_vec_s8, bus.out_last,
                     bus.out_rows, bus.err_ovf, dbg_bank_state);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sync();
        sync();
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;
        sync();
        check_reset_outputs("reset_release");
    endtask

    task automatic test_full_tile();
        logic [31:0] d;
        bus.out_ready = 1'b0;
        for (int r = 0; r < VLEN; r++) begin
            for (int w = 0; w < WPR; w++) begin
                for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(r*16 + w*4 + k);
                send_word(d, 4'hF, w == WPR - 1, (r == VLEN - 1) && (w == WPR - 1));
            end
        end
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_rows !== CNT_W'(VLEN) || bus.out_last !== 1'b0) begin
            fails++;
            $display("FAIL full_tile_head: valid=%b rows=%0d last=%b, required 1 16 0",
                     bus.out_valid, bus.out_rows, bus.out_last);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < VLEN; i++) sync();
        tests++;
        if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL full_tile_rate: valid=%b pending=%0d after 16 cycles, required 0 0",
                     bus.out_valid, exp_q.size());
        end
        wait_drain(50);
    endtask

    task automatic test_partial_mask();
        bus.out_ready = 1'b0;
        send_word(32'h04030201, 4'hF, 1'b0, 1'b0);
        send_word(32'h88776655, 4'b0011, 1'b0, 1'b1);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_rows !== CNT_W'(1) || bus.out_last !== 1'b1) begin
            fails++;
            $display("FAIL partial_ctrl: valid=%b rows=%0d last=%b, required 1 1 1",
                     bus.out_valid, bus.out_rows, bus.out_last);
        end
        tests++;
        if (bus.out_vec_s8[VW-1:48] !== '0 || bus.out_vec_s8[47:0] !== 48'h665504030201) begin
            fails++;
            $display("FAIL partial_bytes: vec=%h, required %h", bus.out_vec_s8,
                     {{(VW-48){1'b0}}, 48'h665504030201});
        end
        bus.out_ready = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_ping_pong();
        bus.out_ready = 1'b0;
        send_tile(3);
        send_tile(3);
        tests++;
        if (bus.in_ready !== 1'b0 || dbg_bank_state !== {FULL, FULL}) begin
            fails++;
            $display("FAIL pingpong_full: in_ready=%b st=%h, required 0 %h",
                     bus.in_ready, dbg_bank_state, {FULL, FULL});
        end
        fork
            send_tile(3);
            begin
                bus.out_ready = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    tests++;
                    if (bus.in_ready !== 1'b0) begin
                        fails++;
                        $display("FAIL pingpong_hold%0d: in_ready=%b, required 0", i, bus.in_ready);
                    end
                    sync();
                end
                @(negedge clk);
                tests++;
                if (bus.in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL pingpong_release: in_ready=%b, required 1", bus.in_ready);
                end
            end
        join
        wait_drain(100);
    endtask

    task automatic test_out_stall();
        int n = 0;
        sent_done = 1'b0;
        fork
            begin
                send_tile(6);
                send_tile(2);
                sent_done = 1'b1;
            end
            begin
                while ((!sent_done || exp_q.size() != 0 || bus.out_valid === 1'b1) && n < 2000) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    sync();
                    n++;
                end
            end
        join
        tests++;
        if (n >= 2000 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL stall_drain: cycles=%0d pending=%0d, required <2000 and 0", n, exp_q.size());
        end
        bus.out_ready = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_overflow();
        tests++;
        if (bus.err_ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_pre: err_ovf=%b, required 0", bus.err_ovf);
        end
        bus.out_ready = 1'b1;
        for (int r = 0; r < VLEN + 1; r++) begin
            for (int w = 0; w < WPR; w++) begin
                send_word($urandom, 4'hF, 1'b0, 1'b0);
            end
            if (r == VLEN - 1) begin
                tests++;
                if (bus.err_ovf !== 1'b1 || bus.in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL ovf_close: err_ovf=%b in_ready=%b, required 1 1",
                             bus.err_ovf, bus.in_ready);
                end
            end
        end
        send_word($urandom, 4'hF, 1'b0, 1'b1);
        wait_drain(100);
        tests++;
        if (bus.err_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: err_ovf=%b, required 1", bus.err_ovf);
        end
    endtask

    task automatic test_reset_mid_fill();
        bus.out_ready = 1'b0;
        send_tile(3);
        for (int i = 0; i < 5; i++) send_word($urandom, 4'hF, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        model_reset();
        sync();
        sync();
        rst_n = 1'b1;
        sync();
        check_reset_outputs("reset_mid_release");
        bus.out_ready = 1'b1;
        send_word(32'hA1A2A3A4, 4'hF, 1'b1, 1'b0);
        send_word(32'hB1B2B3B4, 4'b0101, 1'b0, 1'b1);
        wait_drain(20);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.in_mask       = '0;
        bus.in_row_switch = 1'b0;
        bus.in_last       = 1'b0;
        bus.out_ready     = 1'b0;

        test_reset();
        test_full_tile();
        test_partial_mask();
        test_ping_pong();
        test_out_stall();
        test_overflow();
        test_reset_mid_fill();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fifo_to_vec_s8.md
# fifo_to_vec_s8

Unpacks a stream of 32-bit byte-masked words back into full s8 vectors for the MMA array. It is the inverse of the existing s8-vector-to-32-bit packer. Rows arrive as up to VLEN/4 words, with a row-switch flag on the last word of each row; each completed row becomes one VLEN-byte vector. Rows are collected into a two-bank ping-pong buffer, so one tile can be drained while the next is filled. Each completed tile is replayed as a contiguous vector burst toward the compute array.

## Interface
Parameters:
- VLEN, 16: bytes per vector and maximum rows per bank; must be a multiple of 4 and at least 8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  32  byte i at bits [8i+7:8i]
- in_mask  in  4  in_mask[i]=1 means byte i is valid
- in_row_switch  in  1  this word is the last word of the current row
- in_last  in  1  this word is the last word of the tile (implies row switch)
- out_valid  out  1  out_vec_s8 is valid
- out_ready  in  1  consumer accepts the vector
- out_vec_s8  out  VLEN*8  byte j at bits [8j+7:8j]
- out_last  out  1  final row of the tile
- out_rows  out  clog2(VLEN)+1  row count of the tile being drained
- err_ovf  out  1  sticky row-overflow flag

## Operation
- Input handshake: a word is accepted on in_valid && in_ready.
- Row assembly:
  - word index w runs 0..VLEN/4-1; the accepted word writes row bytes 4w..4w+3.
  - bytes with mask=0 are written as 8'h00.
- Row commit happens on any of:
  - in_row_switch;
  - in_last;
  - w == VLEN/4-1, an implicit row switch.
- On commit:
  - the assembled row, including the current word, is written to bank[wsel] at row wrow.
  - all row bytes not written since the previous commit read as zero.
  - w clears to 0 and wrow increments.
- Tile close happens on in_last, or on a commit when wrow == VLEN-1 without in_last.
  - The second case sets err_ovf, which stays set until reset.
  - On close, the bank is marked full, rows[wsel] = wrow+1, wsel toggles, and wrow clears.
- in_ready = !full[wsel].
- Read side:
  - out_valid = full[rsel].
  - out_vec_s8 = bank[rsel][rptr], forced to 0 when !out_valid.
  - out_last = out_valid && (rptr == rows[rsel]-1).
  - out_rows = rows[rsel] while out_valid, otherwise 0.
- Each out handshake increments rptr. A handshake while out_last is high clears full[rsel] and rptr, then toggles rsel.
- Bank states, per bank: FREE -> FILLING (first word accepted) -> FULL (tile close) -> DRAINING (first out handshake) -> FREE (last handshake). A single-row tile goes FULL -> FREE directly.
- rsel and wsel start at bank 0 and alternate strictly, so tiles are drained in write order.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_vec_s8=0, out_last=0, out_rows=0, err_ovf=0.
  - All pointers, selectors, and full flags are 0.
- Bank memory is not reset.
- Latency: the in_last word accepted at edge N gives out_valid=1 after edge N (first cycle N+1). Out throughput is 1 vector per cycle.
- Bank release: the last-row handshake at edge N clears full; if that bank is wsel, in_ready rises in cycle N+1. No combinational path exists from out_ready to in_ready.
- Simultaneous write-close and drain-complete on opposite banks in the same cycle must both take effect.
- Both banks full: in_ready=0, and the word presented is held, not dropped.
- out_valid, out_vec_s8 and out_last stay stable while out_valid && !out_ready.
- Input fields are don't-care when in_valid=0. in_row_switch is ignored once in_last is high.
- An asynchronous reset mid-tile discards all partial and full tiles. Outputs return to their reset values immediately.

## Structure
- Shared package mma_fifo_pkg holds:
  - VLEN default;
  - WORD_BYTES=4;
  - WORDS_PER_ROW=VLEN/4;
  - pointer width localparams;
  - the bank_state_e enum (FREE, FILLING, FULL, DRAINING).
- The packer and this block both import it.
- One sub-module, vec_s8_row_asm, holds the row register, word index, mask-to-zero fill and commit pulse. The top level holds the banks, selectors and read logic.

## Test plan
- Single full tile:
  - Stimulus: VLEN=16, 16 rows × 4 words, mask 4'hF, in_row_switch on every 4th word, in_last on word 64.
  - Required: 16 vectors match input byte order, out_last only on row 15, out_rows=16.
- Partial row and mask:
  - Stimulus: row of 2 words, second word has mask 4'b0011, with in_last.
  - Required: vector bytes 6..15 = 0, out_rows=1, out_last=1 on the first vector.
- Ping-pong backpressure:
  - Stimulus: send two 3-row tiles with out_ready=0, then a third tile.
  - Required: in_ready=0 after the second in_last; after 3 out handshakes, in_ready=1 on the next cycle; all three tiles come out in order.
- Out stall:
  - Stimulus: toggle out_ready randomly during a drain.
  - Required: no vector is lost or duplicated; data stays stable during stalls.
- Overflow:
  - Stimulus: 17 rows without in_last.
  - Required: tile closes at 16 rows, err_ovf=1 and stays set, row 17 starts the next bank.
- Reset mid-fill:
  - Stimulus: assert rst_n=0 after 5 words.
  - Required: all outputs at reset values; a following tile drains correctly with no stale rows.
